// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word
// reads and hands prefetched words to the control unit over valid/ready.
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] addr_d;
  logic          rd_d;
  logic [CW-1:0] count_q, count_d, count_next, wr_idx;
  logic          pop, push, can_fetch;

  logic [DW-1:0] q_data [DEPTH];
  logic [AW-1:0] q_pc   [DEPTH];

  // Head of the shift queue is entry 0, so ir/ir_pc are plain register outputs.
  assign ir    = q_data[0];
  assign ir_pc = q_pc[0];

  // Handshake and occupancy bookkeeping; a redirect cancels push and pop.
  assign pop        = ir_valid && ir_ready;
  assign push       = (state_q == REQ) && mem_ack && !pc_load;
  assign count_next = count_q + CW'(push) - CW'(pop);
  assign can_fetch  = fetch_en && (count_next < CW'(DEPTH));
  assign wr_idx     = count_q - CW'(pop);

  // Next-state, next fetch PC and next request address.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = mem_addr;
    count_d    = count_next;
    unique case (state_q)
      IDLE: begin
        if (pc_load) begin
          fetch_pc_d = pc_load_value;
        end else if (can_fetch) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (pc_load) begin
          fetch_pc_d = pc_load_value;
          state_d    = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          fetch_pc_d = mem_addr + AW'(1);
          if (can_fetch) begin
            addr_d = mem_addr + AW'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (pc_load) begin
          fetch_pc_d = pc_load_value;
          if (mem_ack) state_d = IDLE;
        end else if (mem_ack) begin
          if (fetch_en) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pc_load) count_d = '0;
    rd_d = (state_d != IDLE);
  end

  // State, PC, request outputs and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_rd     <= 1'b0;
      mem_addr   <= RESET_PC;
      count_q    <= '0;
      ir_valid   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_rd     <= rd_d;
      mem_addr   <= addr_d;
      count_q    <= count_d;
      ir_valid   <= (count_d != '0);
    end
  end

  // Prefetch queue storage: shift toward the head on pop, write at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (!pc_load) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (pop && (CW'(i + 1) < count_q)) begin
          q_data[i] <= q_data[i+1];
          q_pc[i]   <= q_pc[i+1];
        end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push && (CW'(i) == wr_idx)) begin
          q_data[i] <= mem_rdata;
          q_pc[i]   <= mem_addr;
        end
      end
    end
  end

  // Requests are only issued with a free slot, so a push can never overflow.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q >= CW'(DEPTH))));

endmodule
